// File: rtl/aes_word_stream.sv
// aes_word_stream
//   Word-serial wrapper around a single-cycle combinational AES-128 core.
//   Collects four 32-bit words into either the key or the plaintext
//   register, lets the unclocked core settle for SETTLE_CYCLES cycles,
//   captures the ciphertext and returns it as four 32-bit words.
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   in_valid/in_ready   input word handshake; in_data MS word first,
//                       in_is_key selects the group type on the 1st word
//   core_plain_text     plaintext register to the core
//   core_cipher_key     key register to the core
//   core_cipher_text    ciphertext from the core
//   out_valid/out_ready output word handshake; out_data MS word first,
//                       out_last flags the 4th word
//   busy                high while settling or emitting
//   blk_cnt             completed-block count, wraps
//
// state  | meaning
// -------+-----------------------------------------------------------
// LOAD   | accepting key / plaintext words
// SETTLE | plaintext complete, waiting for the core to settle
// EMIT   | presenting captured ciphertext words to the output

module aes_word_stream #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_is_key,
  output logic [127:0]     core_plain_text,
  output logic [127:0]     core_cipher_key,
  input  logic [127:0]     core_cipher_text,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_last,
  output logic             busy,
  output logic [CNT_W-1:0] blk_cnt
);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SETTLE = 2'd1,
    EMIT   = 2'd2
  } state_e;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_e           state_q;
  logic [127:0]     key_q;
  logic [127:0]     pt_q;
  logic [127:0]     ct_q;
  logic [1:0]       widx_q;
  logic [1:0]       oidx_q;
  logic             grp_key_q;
  logic [3:0]       settle_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             out_last_q;
  logic             busy_q;
  logic [CNT_W-1:0] blk_q;

  // Group type comes from in_is_key only on the first word of a group.
  logic word_is_key;
  assign word_is_key = (widx_q == 2'd0) ? in_is_key : grp_key_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      key_q       <= '0;
      pt_q        <= '0;
      ct_q        <= '0;
      widx_q      <= '0;
      oidx_q      <= '0;
      grp_key_q   <= 1'b0;
      settle_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      blk_q       <= '0;
    end else begin
      case (state_q)
        LOAD: begin
          if (in_valid) begin
            if (word_is_key) key_q[127 - 32*int'(widx_q) -: 32] <= in_data;
            else             pt_q[127 - 32*int'(widx_q) -: 32]  <= in_data;
            if (widx_q == 2'd0) grp_key_q <= in_is_key;
            widx_q <= widx_q + 2'd1;
            if (widx_q == 2'd3 && !word_is_key) begin
              state_q    <= SETTLE;
              settle_q   <= '0;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b1;
            end
          end
        end
        SETTLE: begin
          settle_q <= settle_q + 4'd1;
          if (settle_q == SETTLE_LAST) begin
            ct_q        <= core_cipher_text;
            out_valid_q <= 1'b1;
            out_last_q  <= 1'b0;
            oidx_q      <= '0;
            state_q     <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            // ct_q is a shift register: the presented word is always its top word.
            ct_q <= {ct_q[95:0], 32'h0};
            if (oidx_q == 2'd3) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              oidx_q      <= '0;
              blk_q       <= blk_q + CNT_W'(1);
              in_ready_q  <= 1'b1;
              busy_q      <= 1'b0;
              state_q     <= LOAD;
            end else begin
              oidx_q     <= oidx_q + 2'd1;
              out_last_q <= (oidx_q == 2'd2);
            end
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  assign in_ready        = in_ready_q;
  assign out_valid       = out_valid_q;
  assign out_data        = ct_q[127:96];
  assign out_last        = out_last_q;
  assign busy            = busy_q;
  assign blk_cnt         = blk_q;
  assign core_plain_text = pt_q;
  assign core_cipher_key = key_q;

endmodule

// File: tb/tb_aes_word_stream.sv
module tb_aes_word_stream;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic [2:0]   in_valid_v  = '0;
  logic [2:0]   in_is_key_v = '0;
  logic [2:0]   out_ready_v = '0;
  logic [95:0]  in_data_v   = '0;
  wire  [2:0]   in_ready_v, out_valid_v, out_last_v, busy_v;
  wire  [95:0]  out_data_v;
  wire  [383:0] core_pt_v, core_key_v, core_ct_v;
  wire  [15:0]  blk0, blk2;
  wire  [1:0]   blk1;

  int cyc    = 0;
  int tests  = 0;
  int failed = 0;

  logic [127:0] key_m[3];
  logic [127:0] pt_m[3];
  int           blk_m[3];
  int           lat[3]     = '{2, 1, 15};
  int           cnt_mod[3] = '{65536, 4, 65536};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for the combinational AES core: exact for the FIPS-197 C.1
  // vector, otherwise a key-dependent mix so wrong keys/orders are visible.
  function automatic logic [127:0] ref_core(input logic [127:0] k, input logic [127:0] p);
    if (k == FIPS_KEY && p == FIPS_PT) return FIPS_CT;
    return {p[95:0], p[127:96]} ^ {k[63:0], k[127:64]} ^ 128'h5a5a_3c3c_0f0f_9696_a5a5_c3c3_f0f0_6969;
  endfunction

  assign core_ct_v[127:0]   = ref_core(core_key_v[127:0],   core_pt_v[127:0]);
  assign core_ct_v[255:128] = ref_core(core_key_v[255:128], core_pt_v[255:128]);
  assign core_ct_v[383:256] = ref_core(core_key_v[383:256], core_pt_v[383:256]);

  aes_word_stream #(.SETTLE_CYCLES(2), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .in_data(in_data_v[31:0]), .in_is_key(in_is_key_v[0]),
    .core_plain_text(core_pt_v[127:0]), .core_cipher_key(core_key_v[127:0]),
    .core_cipher_text(core_ct_v[127:0]), .out_valid(out_valid_v[0]),
    .out_ready(out_ready_v[0]), .out_data(out_data_v[31:0]), .out_last(out_last_v[0]),
    .busy(busy_v[0]), .blk_cnt(blk0));

  aes_word_stream #(.SETTLE_CYCLES(1), .CNT_W(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .in_data(in_data_v[63:32]), .in_is_key(in_is_key_v[1]),
    .core_plain_text(core_pt_v[255:128]), .core_cipher_key(core_key_v[255:128]),
    .core_cipher_text(core_ct_v[255:128]), .out_valid(out_valid_v[1]),
    .out_ready(out_ready_v[1]), .out_data(out_data_v[63:32]), .out_last(out_last_v[1]),
    .busy(busy_v[1]), .blk_cnt(blk1));

  aes_word_stream #(.SETTLE_CYCLES(15), .CNT_W(16)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .in_data(in_data_v[95:64]), .in_is_key(in_is_key_v[2]),
    .core_plain_text(core_pt_v[383:256]), .core_cipher_key(core_key_v[383:256]),
    .core_cipher_text(core_ct_v[383:256]), .out_valid(out_valid_v[2]),
    .out_ready(out_ready_v[2]), .out_data(out_data_v[95:64]), .out_last(out_last_v[2]),
    .busy(busy_v[2]), .blk_cnt(blk2));

  function automatic logic [127:0] key_of(input int i);
    return core_key_v[i*128 +: 128];
  endfunction

  function automatic logic [127:0] pt_of(input int i);
    return core_pt_v[i*128 +: 128];
  endfunction

  function automatic int get_blk(input int i);
    case (i)
      0:       return int'(blk0);
      1:       return int'(blk1);
      default: return int'(blk2);
    endcase
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic send_word(input int i, input logic [31:0] d, input bit k, output int acc);
    int n = 0;
    in_data_v[i*32 +: 32] = d;
    in_is_key_v[i] = k;
    in_valid_v[i] = 1'b1;
    while (in_ready_v[i] !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    tests++;
    if (in_ready_v[i] !== 1'b1) begin
      failed++; $display("FAIL accept_timeout[%0d]: in_ready=%b required 1", i, in_ready_v[i]);
    end
    @(posedge clk); #1;
    acc = cyc;
    in_valid_v[i] = 1'b0;
  endtask

  task automatic load_group(input int i, input logic [127:0] data, input bit first_key,
                            input bit rest_key, output int acc);
    for (int w = 0; w < 4; w++)
      send_word(i, data[127-32*w -: 32], (w == 0) ? first_key : rest_key, acc);
  endtask

  task automatic wait_valid(input int i, input int acc);
    int n = 0;
    while (out_valid_v[i] !== 1'b1 && n < 40) begin
      tests++;
      if (busy_v[i] !== 1'b1 || in_ready_v[i] !== 1'b0) begin
        failed++; $display("FAIL settle_flags[%0d]: busy=%b in_ready=%b required 1/0", i, busy_v[i], in_ready_v[i]);
      end
      tests++;
      if (key_of(i) !== key_m[i] || pt_of(i) !== pt_m[i]) begin
        failed++; $display("FAIL settle_regs[%0d]: key=%h pt=%h required %h %h", i, key_of(i), pt_of(i), key_m[i], pt_m[i]);
      end
      @(posedge clk); #1; n++;
    end
    tests++;
    if (out_valid_v[i] !== 1'b1) begin
      failed++; $display("FAIL settle_timeout[%0d]: out_valid=%b required 1", i, out_valid_v[i]);
    end else if (cyc - acc != lat[i]) begin
      failed++; $display("FAIL latency[%0d]: got %0d cycles required %0d", i, cyc - acc, lat[i]);
    end
  endtask

  // mode 0: always ready; mode 1: stall 5 cycles on word index 1, then toggle.
  task automatic recv_block(input int i, input logic [127:0] ct, input int mode);
    int k = 0, guard = 0, stall = 0;
    bit tog = 1'b1, rdy;
    logic [31:0] exp_w;
    while (k < 4 && guard < 200) begin
      exp_w = ct[127-32*k -: 32];
      if (mode == 1 && k == 1 && stall < 5) rdy = 1'b0;
      else if (mode == 1 && k >= 1) begin rdy = tog; tog = ~tog; end
      else rdy = 1'b1;
      out_ready_v[i] = rdy;
      tests++;
      if (out_valid_v[i] !== 1'b1) begin
        failed++; $display("FAIL out_valid[%0d] word %0d: got %b required 1", i, k, out_valid_v[i]);
      end
      tests++;
      if (out_data_v[i*32 +: 32] !== exp_w) begin
        failed++; $display("FAIL out_data[%0d] word %0d: got %h required %h", i, k, out_data_v[i*32 +: 32], exp_w);
      end
      tests++;
      if (out_last_v[i] !== (k == 3)) begin
        failed++; $display("FAIL out_last[%0d] word %0d: got %b required %b", i, k, out_last_v[i], (k == 3));
      end
      tests++;
      if (in_ready_v[i] !== 1'b0 || busy_v[i] !== 1'b1) begin
        failed++; $display("FAIL emit_flags[%0d]: in_ready=%b busy=%b required 0/1", i, in_ready_v[i], busy_v[i]);
      end
      tests++;
      if (key_of(i) !== key_m[i]) begin
        failed++; $display("FAIL emit_key[%0d]: got %h required %h", i, key_of(i), key_m[i]);
      end
      @(posedge clk); #1;
      if (rdy) k++; else stall++;
      guard++;
    end
    out_ready_v[i] = 1'b0;
    tests++;
    if (out_valid_v[i] !== 1'b0 || out_last_v[i] !== 1'b0 || busy_v[i] !== 1'b0 || in_ready_v[i] !== 1'b1) begin
      failed++; $display("FAIL emit_done[%0d]: valid=%b last=%b busy=%b in_ready=%b required 0/0/0/1",
                         i, out_valid_v[i], out_last_v[i], busy_v[i], in_ready_v[i]);
    end
  endtask

  task automatic run_block(input int i, input logic [127:0] pt, input logic [127:0] exp_ct, input int mode);
    int acc;
    load_group(i, pt, 1'b0, 1'b0, acc);
    pt_m[i] = pt;
    wait_valid(i, acc);
    recv_block(i, exp_ct, mode);
    blk_m[i]++;
    tests++;
    if (get_blk(i) != blk_m[i] % cnt_mod[i]) begin
      failed++; $display("FAIL blk_cnt[%0d]: got %0d required %0d", i, get_blk(i), blk_m[i] % cnt_mod[i]);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (in_ready_v[i] !== 1'b1 || out_valid_v[i] !== 1'b0 || out_last_v[i] !== 1'b0 || busy_v[i] !== 1'b0) begin
        failed++; $display("FAIL reset_flags[%0d]: in_ready=%b valid=%b last=%b busy=%b", i,
                           in_ready_v[i], out_valid_v[i], out_last_v[i], busy_v[i]);
      end
      tests++;
      if (out_data_v[i*32 +: 32] !== 32'h0 || get_blk(i) != 0) begin
        failed++; $display("FAIL reset_data[%0d]: out_data=%h blk=%0d required 0/0", i, out_data_v[i*32 +: 32], get_blk(i));
      end
      tests++;
      if (key_of(i) !== 128'h0 || pt_of(i) !== 128'h0) begin
        failed++; $display("FAIL reset_regs[%0d]: key=%h pt=%h required 0", i, key_of(i), pt_of(i));
      end
    end
  endtask

  task automatic test_fips();
    int acc;
    load_group(0, FIPS_KEY, 1'b1, 1'b1, acc);
    key_m[0] = FIPS_KEY;
    @(posedge clk); #1;
    tests++;
    if (key_of(0) !== FIPS_KEY || busy_v[0] !== 1'b0 || out_valid_v[0] !== 1'b0) begin
      failed++; $display("FAIL fips_key_load: key=%h busy=%b valid=%b required %h/0/0", key_of(0), busy_v[0], out_valid_v[0], FIPS_KEY);
    end
    run_block(0, FIPS_PT, FIPS_CT, 0);
  endtask

  task automatic test_key_reuse();
    logic [127:0] pt = rand128();
    run_block(0, pt, ref_core(key_m[0], pt), 0);
  endtask

  task automatic test_backpressure();
    logic [127:0] pt = rand128();
    run_block(0, pt, ref_core(key_m[0], pt), 1);
  endtask

  task automatic test_type_latch();
    int acc;
    logic [127:0] w = rand128();
    load_group(0, w, 1'b1, 1'b0, acc);
    key_m[0] = w;
    for (int n = 0; n < 20; n++) begin
      tests++;
      if (out_valid_v[0] !== 1'b0 || busy_v[0] !== 1'b0 || in_ready_v[0] !== 1'b1) begin
        failed++; $display("FAIL latch_no_settle: valid=%b busy=%b in_ready=%b required 0/0/1", out_valid_v[0], busy_v[0], in_ready_v[0]);
      end
      @(posedge clk); #1;
    end
    tests++;
    if (key_of(0) !== w || pt_of(0) !== pt_m[0]) begin
      failed++; $display("FAIL latch_regs: key=%h pt=%h required %h %h", key_of(0), pt_of(0), w, pt_m[0]);
    end
    w = rand128();
    run_block(0, w, ref_core(key_m[0], w), 0);
  endtask

  task automatic test_partial_idle();
    int acc;
    logic [127:0] pt = rand128();
    send_word(0, pt[127:96], 1'b0, acc);
    send_word(0, pt[95:64], 1'b0, acc);
    for (int n = 0; n < 10; n++) begin
      tests++;
      if (busy_v[0] !== 1'b0 || out_valid_v[0] !== 1'b0 || in_ready_v[0] !== 1'b1) begin
        failed++; $display("FAIL partial_idle: busy=%b valid=%b in_ready=%b required 0/0/1", busy_v[0], out_valid_v[0], in_ready_v[0]);
      end
      @(posedge clk); #1;
    end
    tests++;
    if (pt_of(0) !== {pt[127:64], pt_m[0][63:0]} || key_of(0) !== key_m[0]) begin
      failed++; $display("FAIL partial_regs: pt=%h required %h", pt_of(0), {pt[127:64], pt_m[0][63:0]});
    end
    // in_is_key on later words must be ignored
    send_word(0, pt[63:32], 1'b1, acc);
    send_word(0, pt[31:0], 1'b1, acc);
    pt_m[0] = pt;
    wait_valid(0, acc);
    recv_block(0, ref_core(key_m[0], pt), 0);
    blk_m[0]++;
    tests++;
    if (get_blk(0) != blk_m[0] % cnt_mod[0]) begin
      failed++; $display("FAIL blk_cnt[0]: got %0d required %0d", get_blk(0), blk_m[0] % cnt_mod[0]);
    end
  endtask

  task automatic test_reset_mid_emit();
    int acc;
    logic [127:0] pt = rand128();
    logic [127:0] ct;
    ct = ref_core(key_m[0], pt);
    load_group(0, pt, 1'b0, 1'b0, acc);
    pt_m[0] = pt;
    wait_valid(0, acc);
    out_ready_v[0] = 1'b1;
    @(posedge clk); #1;
    out_ready_v[0] = 1'b0;
    tests++;
    if (out_data_v[31:0] !== ct[95:64]) begin
      failed++; $display("FAIL mid_emit_word: got %h required %h", out_data_v[31:0], ct[95:64]);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (in_ready_v[0] !== 1'b1 || out_valid_v[0] !== 1'b0 || out_last_v[0] !== 1'b0 || busy_v[0] !== 1'b0) begin
      failed++; $display("FAIL async_reset_flags: in_ready=%b valid=%b last=%b busy=%b required 1/0/0/0",
                         in_ready_v[0], out_valid_v[0], out_last_v[0], busy_v[0]);
    end
    tests++;
    if (out_data_v[31:0] !== 32'h0 || get_blk(0) != 0 || key_of(0) !== 128'h0 || pt_of(0) !== 128'h0) begin
      failed++; $display("FAIL async_reset_regs: data=%h blk=%0d key=%h pt=%h required all 0",
                         out_data_v[31:0], get_blk(0), key_of(0), pt_of(0));
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      key_m[i] = '0; pt_m[i] = '0; blk_m[i] = 0;
    end
    @(posedge clk); #1;
    pt = rand128();
    run_block(0, pt, ref_core(128'h0, pt), 0);
  endtask

  task automatic test_settle_instance(input int i, input int nblk);
    int acc;
    logic [127:0] v;
    for (int b = 0; b < nblk; b++) begin
      if ($urandom_range(1, 0) == 1) begin
        v = rand128();
        load_group(i, v, 1'b1, 1'b1, acc);
        key_m[i] = v;
      end
      v = rand128();
      run_block(i, v, ref_core(key_m[i], v), 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      key_m[i] = '0; pt_m[i] = '0; blk_m[i] = 0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_fips();
    test_key_reuse();
    test_backpressure();
    test_type_latch();
    test_partial_idle();
    test_reset_mid_emit();
    test_settle_instance(1, 6);
    test_settle_instance(2, 2);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/aes_word_stream.md
Name: aes_word_stream

Overview:
Sequential front/back-end for the single-cycle-combinational 128-bit AES encryption core. It assembles 32-bit input words into a 128-bit cipher key and a 128-bit plaintext block, and drives them into the core. It waits a programmable number of cycles for the unclocked core to settle, captures the ciphertext, and serialises it back out as four 32-bit words over a valid/ready handshake.

Parameters:
SETTLE_CYCLES, 2, cycles allowed for the combinational core to settle before capture; legal range 1..15.
CNT_W, 16, width of the completed-block counter.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  reset; asynchronous, active-low.
in_valid  input  1  an input word is offered.
in_ready  output  1  block accepts in_data on this cycle.
in_data  input  32  key or plaintext word, most-significant word first.
in_is_key  input  1  1 = the word belongs to a key group; 0 = the word belongs to a plaintext group.
core_plain_text  output  128  plaintext register driven to the core.
core_cipher_key  output  128  key register driven to the core.
core_cipher_text  input  128  ciphertext returned by the core.
out_valid  output  1  an output word is presented.
out_ready  input  1  downstream accepts out_data.
out_data  output  32  ciphertext word, most-significant word first.
out_last  output  1  marks the 4th (least-significant) ciphertext word.
busy  output  1  high in SETTLE or EMIT.
blk_cnt  output  CNT_W  count of completed blocks; wraps modulo 2^CNT_W.

Behaviour:
- Handshake transfer happens when valid&&ready on a rising edge. valid must not depend on ready.
- States: LOAD, SETTLE, EMIT. Reset state is LOAD.
- Reset values: in_ready=1, out_valid=0, out_data=0, out_last=0, busy=0, blk_cnt=0, key register=0, plaintext register=0, word index=0, settle counter=0.
- An asserted rst_n low mid-operation aborts immediately to these values. Any partial group and any pending output are discarded.
- LOAD: in_ready=1.
  - The group type is latched from in_is_key on the 1st accepted word (index 0). in_is_key is ignored on words 1..3.
  - Word k (k=0..3) is written to bits [127-32k -: 32] of the key register or of the plaintext register, according to the latched type.
  - The word index wraps 3->0 on the 4th accepted word.
  - Completed key group: stay in LOAD. The new key applies to all following plaintext blocks until it is replaced.
  - Completed plaintext group: go to SETTLE with the settle counter at 0.
  - A plaintext group with no key ever loaded encrypts under the all-zero key. This is legal.
- SETTLE: in_ready=0, busy=1. The settle counter increments every cycle. On the edge where the counter equals SETTLE_CYCLES-1:
  - capture core_cipher_text into the output shift register;
  - set out_valid=1 and out_index=0;
  - go to EMIT.
- Latency: out_valid first rises exactly SETTLE_CYCLES cycles after the edge that accepts the 4th plaintext word.
- EMIT: in_ready=0, busy=1. out_data is bits [127-32k -: 32] of the captured ciphertext for out_index k. out_last=1 only when k=3.
  - When out_ready is low, out_data, out_last and out_valid stay stable.
  - On transfer with k<3: k is incremented.
  - On transfer with k=3: out_valid=0, out_last=0, blk_cnt increments, go to LOAD.
  - The next input word is accepted no earlier than the cycle after the last output transfer.
- core_plain_text and core_cipher_key are register outputs only. They change only on accepted input words, never during SETTLE or EMIT.
- Cycles with in_valid low in LOAD leave all state unchanged. A partial group waits indefinitely.

Test Plan:
- FIPS-197 C.1 vector. Key words 00010203, 04050607, 08090a0b, 0c0d0e0f (in_is_key=1). Plaintext words 00112233, 44556677, 8899aabb, ccddeeff. Required response: out words 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a; out_last on the 4th only; blk_cnt=1; out_valid rises 2 cycles after the last plaintext accept.
- Key reuse: after test 1, send a second plaintext block without reloading the key. Required response: the same key is used, blk_cnt=2, and the key register is unchanged throughout.
- Backpressure: hold out_ready=0 for 5 cycles on word 1, then toggle it every cycle. Required response: out_data holds 6a7b0430 while stalled, the word order is preserved, and in_ready stays 0 until after the final transfer.
- Type latching: 1st word with in_is_key=1, words 2-4 with in_is_key=0. Required response: all 4 words go to the key register, there is no SETTLE entry, and out_valid stays 0.
- Reset mid-EMIT: assert rst_n low after word 1 transfers. Required response: all outputs return to reset values asynchronously (before the next clock edge), in_ready=1, and a subsequent plaintext block encrypts under the zero key.
- SETTLE_CYCLES=1 and SETTLE_CYCLES=15 builds: out_valid rises 1 cycle and 15 cycles respectively after the 4th plaintext accept. blk_cnt wraps to 0 after 2^CNT_W blocks (run with CNT_W=2).
